// File: rtl/m_out_port_if.sv
// Bus, handshake and serial-line signals of the bus-to-device output port.
interface m_out_port_if #(
   parameter int unsigned WIDTH = 8
);
   logic [WIDTH-1:0] iData;
   logic             iLoad;
   logic             iSerialStart;
   logic             iAck;
   logic [WIDTH-1:0] oPort;
   logic             oStrobe;
   logic             oFull;
   logic             oSerial;
   logic             oBusy;

   // Host/bus side drives commands and observes the port.
   modport master (
      output iData, iLoad, iSerialStart, iAck,
      input  oPort, oStrobe, oFull, oSerial, oBusy
   );

   // Port side receives commands and drives the device-facing outputs.
   modport slave (
      input  iData, iLoad, iSerialStart, iAck,
      output oPort, oStrobe, oFull, oSerial, oBusy
   );
endinterface

// File: rtl/m_out_port.sv
// Bus-to-device output port: latches the shared bus on load, runs a
// strobe/acknowledge handshake and can send the held byte as a serial frame.
module m_out_port #(
   parameter int unsigned WIDTH        = 8,
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input logic          iClk,
   input logic          iReset,
   m_out_port_if.slave  bus
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} stateT;

   stateT            state;
   logic [CNT_W-1:0] cycleCnt;
   logic [BIT_W-1:0] bitCnt;
   logic [WIDTH-1:0] shiftReg;
   logic [WIDTH-1:0] portReg;
   logic             strobeReg;
   logic             fullReg;
   logic             serialReg;
   logic             busyReg;
   logic             loadOk;

   // A load is only taken while no frame is in flight.
   assign loadOk = bus.iLoad && !busyReg;

   // Handshake register and serial framer; every output is a flop.
   always_ff @(posedge iClk or posedge iReset) begin
      if (iReset) begin
         state     <= IDLE;
         cycleCnt  <= '0;
         bitCnt    <= '0;
         shiftReg  <= '0;
         portReg   <= '0;
         strobeReg <= 1'b0;
         fullReg   <= 1'b0;
         serialReg <= 1'b1;
         busyReg   <= 1'b0;
      end else begin
         strobeReg <= loadOk;
         if (loadOk) begin
            portReg <= bus.iData;
            fullReg <= 1'b1;
         end else if (bus.iAck) begin
            fullReg <= 1'b0;
         end

         case (state)
            IDLE: begin
               serialReg <= 1'b1;
               busyReg   <= 1'b0;
               // Same-edge load wins; the start request is dropped.
               if (bus.iSerialStart && !bus.iLoad) begin
                  shiftReg  <= portReg;
                  cycleCnt  <= CNT_RELOAD;
                  serialReg <= 1'b0;
                  busyReg   <= 1'b1;
                  state     <= START;
               end
            end
            START: begin
               if (cycleCnt == '0) begin
                  cycleCnt  <= CNT_RELOAD;
                  bitCnt    <= '0;
                  serialReg <= shiftReg[0];
                  state     <= DATA;
               end else begin
                  cycleCnt <= cycleCnt - CNT_W'(1);
               end
            end
            DATA: begin
               if (cycleCnt == '0) begin
                  cycleCnt <= CNT_RELOAD;
                  if (bitCnt == LAST_BIT) begin
                     serialReg <= 1'b1;
                     state     <= STOP;
                  end else begin
                     shiftReg  <= shiftReg >> 1;
                     serialReg <= shiftReg[1];
                     bitCnt    <= bitCnt + BIT_W'(1);
                  end
               end else begin
                  cycleCnt <= cycleCnt - CNT_W'(1);
               end
            end
            STOP: begin
               if (cycleCnt == '0) begin
                  // Back-to-back frames may start on the stop-completion edge.
                  if (bus.iSerialStart) begin
                     shiftReg  <= portReg;
                     cycleCnt  <= CNT_RELOAD;
                     serialReg <= 1'b0;
                     state     <= START;
                  end else begin
                     serialReg <= 1'b1;
                     busyReg   <= 1'b0;
                     state     <= IDLE;
                  end
               end else begin
                  cycleCnt <= cycleCnt - CNT_W'(1);
               end
            end
            default: begin
               serialReg <= 1'b1;
               busyReg   <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

   assign bus.oPort   = portReg;
   assign bus.oStrobe = strobeReg;
   assign bus.oFull   = fullReg;
   assign bus.oSerial = serialReg;
   assign bus.oBusy   = busyReg;

endmodule

// File: tb/tb_m_out_port.sv
// Self-checking bench for m_out_port: directed scenarios plus a randomized
// run against a cycle-level behavioural model of the port.
module tb_m_out_port;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned CPB   = 4;
   localparam int FRAME = (WIDTH + 2) * CPB;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   m_out_port_if #(.WIDTH(WIDTH)) bus ();

   m_out_port #(.WIDTH(WIDTH), .CLKS_PER_BIT(CPB)) dut (
      .iClk   (clk),
      .iReset (rst),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clearInputs;
      bus.iData        = '0;
      bus.iLoad        = 1'b0;
      bus.iSerialStart = 1'b0;
      bus.iAck         = 1'b0;
   endtask

   task automatic test_reset;
      bus.iData = 8'h5A; bus.iLoad = 1'b1;
      tick;
      bus.iLoad = 1'b0; bus.iSerialStart = 1'b1;
      tick;
      bus.iSerialStart = 1'b0;
      tick; tick;
      #2 rst = 1'b1;
      #1;
      checks++; if (bus.oPort !== 8'h00) begin errors++; $display("FAIL reset_port: got %h expected 00", bus.oPort); end
      checks++; if (bus.oStrobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b expected 0", bus.oStrobe); end
      checks++; if (bus.oFull !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", bus.oFull); end
      checks++; if (bus.oSerial !== 1'b1) begin errors++; $display("FAIL reset_serial: got %b expected 1", bus.oSerial); end
      checks++; if (bus.oBusy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.oBusy); end
      #2 rst = 1'b0;
      tick;
      checks++; if (bus.oBusy !== 1'b0 || bus.oSerial !== 1'b1) begin errors++; $display("FAIL reset_idle_after: busy %b serial %b expected 0 1", bus.oBusy, bus.oSerial); end
   endtask

   task automatic test_load_ack;
      bus.iData = 8'hA5; bus.iLoad = 1'b1;
      tick;
      bus.iLoad = 1'b0;
      checks++; if (bus.oPort !== 8'hA5) begin errors++; $display("FAIL load_port: got %h expected a5", bus.oPort); end
      checks++; if (bus.oStrobe !== 1'b1) begin errors++; $display("FAIL load_strobe_on: got %b expected 1", bus.oStrobe); end
      checks++; if (bus.oFull !== 1'b1) begin errors++; $display("FAIL load_full: got %b expected 1", bus.oFull); end
      tick;
      checks++; if (bus.oStrobe !== 1'b0) begin errors++; $display("FAIL load_strobe_off: got %b expected 0", bus.oStrobe); end
      bus.iAck = 1'b1;
      tick;
      bus.iAck = 1'b0;
      checks++; if (bus.oFull !== 1'b0) begin errors++; $display("FAIL ack_full: got %b expected 0", bus.oFull); end
      checks++; if (bus.oPort !== 8'hA5) begin errors++; $display("FAIL ack_port_hold: got %h expected a5", bus.oPort); end
      bus.iAck = 1'b1;
      tick;
      bus.iAck = 1'b0;
      checks++; if (bus.oFull !== 1'b0) begin errors++; $display("FAIL ack_when_empty: got %b expected 0", bus.oFull); end
   endtask

   // Frame of 0xA5 with an ignored load in the middle.
   task automatic test_serial_frame;
      logic [9:0] frameBits;
      frameBits = {1'b1, 8'hA5, 1'b0};
      bus.iSerialStart = 1'b1;
      tick;
      bus.iSerialStart = 1'b0;
      for (int k = 0; k < FRAME; k++) begin
         checks++; if (bus.oSerial !== frameBits[k / CPB]) begin errors++; $display("FAIL frame_serial k=%0d: got %b expected %b", k, bus.oSerial, frameBits[k / CPB]); end
         checks++; if (bus.oBusy !== 1'b1) begin errors++; $display("FAIL frame_busy k=%0d: got %b expected 1", k, bus.oBusy); end
         if (k == 10) begin
            bus.iData = 8'h3C; bus.iLoad = 1'b1;
         end
         if (k == 11) begin
            bus.iLoad = 1'b0;
            checks++; if (bus.oPort !== 8'hA5) begin errors++; $display("FAIL busy_load_port: got %h expected a5", bus.oPort); end
            checks++; if (bus.oStrobe !== 1'b0) begin errors++; $display("FAIL busy_load_strobe: got %b expected 0", bus.oStrobe); end
            checks++; if (bus.oFull !== 1'b0) begin errors++; $display("FAIL busy_load_full: got %b expected 0", bus.oFull); end
         end
         tick;
      end
      checks++; if (bus.oBusy !== 1'b0) begin errors++; $display("FAIL frame_end_busy: got %b expected 0", bus.oBusy); end
      checks++; if (bus.oSerial !== 1'b1) begin errors++; $display("FAIL frame_end_serial: got %b expected 1", bus.oSerial); end
   endtask

   task automatic test_same_edge;
      bus.iData = 8'h22; bus.iLoad = 1'b1;
      tick;
      bus.iLoad = 1'b0;
      tick;
      bus.iData = 8'h11; bus.iLoad = 1'b1; bus.iAck = 1'b1;
      tick;
      bus.iLoad = 1'b0; bus.iAck = 1'b0;
      checks++; if (bus.oPort !== 8'h11) begin errors++; $display("FAIL load_ack_port: got %h expected 11", bus.oPort); end
      checks++; if (bus.oFull !== 1'b1) begin errors++; $display("FAIL load_ack_full: got %b expected 1", bus.oFull); end
      checks++; if (bus.oStrobe !== 1'b1) begin errors++; $display("FAIL load_ack_strobe: got %b expected 1", bus.oStrobe); end
      tick;
      bus.iData = 8'h77; bus.iLoad = 1'b1; bus.iSerialStart = 1'b1;
      tick;
      bus.iLoad = 1'b0; bus.iSerialStart = 1'b0;
      checks++; if (bus.oPort !== 8'h77) begin errors++; $display("FAIL load_start_port: got %h expected 77", bus.oPort); end
      checks++; if (bus.oBusy !== 1'b0) begin errors++; $display("FAIL load_start_busy: got %b expected 0", bus.oBusy); end
      checks++; if (bus.oSerial !== 1'b1) begin errors++; $display("FAIL load_start_serial: got %b expected 1", bus.oSerial); end
      tick;
      checks++; if (bus.oBusy !== 1'b0 || bus.oSerial !== 1'b1) begin errors++; $display("FAIL load_start_later: busy %b serial %b expected 0 1", bus.oBusy, bus.oSerial); end
   endtask

   // Reset during data bit 2, then a clean frame of the cleared port.
   task automatic test_reset_mid_frame;
      bus.iSerialStart = 1'b1;
      tick;
      bus.iSerialStart = 1'b0;
      for (int k = 0; k < 13; k++) tick;
      checks++; if (bus.oBusy !== 1'b1) begin errors++; $display("FAIL midreset_pre_busy: got %b expected 1", bus.oBusy); end
      #2 rst = 1'b1;
      #1;
      checks++; if (bus.oSerial !== 1'b1) begin errors++; $display("FAIL midreset_serial: got %b expected 1", bus.oSerial); end
      checks++; if (bus.oBusy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", bus.oBusy); end
      checks++; if (bus.oPort !== 8'h00) begin errors++; $display("FAIL midreset_port: got %h expected 00", bus.oPort); end
      #2 rst = 1'b0;
      tick;
      bus.iSerialStart = 1'b1;
      tick;
      bus.iSerialStart = 1'b0;
      for (int k = 0; k < FRAME; k++) begin
         checks++; if (bus.oSerial !== (k >= FRAME - CPB)) begin errors++; $display("FAIL zero_frame k=%0d: got %b expected %b", k, bus.oSerial, (k >= FRAME - CPB)); end
         checks++; if (bus.oBusy !== 1'b1) begin errors++; $display("FAIL zero_frame_busy k=%0d: got %b expected 1", k, bus.oBusy); end
         tick;
      end
      checks++; if (bus.oBusy !== 1'b0) begin errors++; $display("FAIL zero_frame_end: got %b expected 0", bus.oBusy); end
   endtask

   // Random commands checked against an elapsed-time model of the port.
   task automatic test_random;
      logic [7:0] mPort;
      logic       mFull;
      logic       mStrobe;
      int         mElapsed;
      logic [9:0] mFrame;
      logic       ld, st, ak, busy, loadOk, frameEnd, startOk, expSerial;
      logic [7:0] dat;
      rst = 1'b1;
      #2 rst = 1'b0;
      tick;
      mPort = '0; mFull = 1'b0; mStrobe = 1'b0; mElapsed = -1; mFrame = '1;
      for (int n = 0; n < 600; n++) begin
         ld  = ($urandom % 8) == 0;
         st  = ($urandom % 5) == 0;
         ak  = ($urandom % 4) == 0;
         dat = 8'($urandom);
         bus.iData = dat; bus.iLoad = ld; bus.iSerialStart = st; bus.iAck = ak;
         busy     = mElapsed >= 0;
         loadOk   = ld && !busy;
         frameEnd = busy && (mElapsed == FRAME - 1);
         startOk  = st && ((!busy && !ld) || frameEnd);
         if (startOk) begin
            mFrame   = {1'b1, mPort, 1'b0};
            mElapsed = 0;
         end else if (busy) begin
            mElapsed++;
            if (mElapsed == FRAME) mElapsed = -1;
         end
         mStrobe = loadOk;
         if (loadOk) begin
            mPort = dat; mFull = 1'b1;
         end else if (ak) begin
            mFull = 1'b0;
         end
         expSerial = (mElapsed < 0) ? 1'b1 : mFrame[mElapsed / CPB];
         tick;
         checks++; if (bus.oPort !== mPort) begin errors++; $display("FAIL rnd_port n=%0d: got %h expected %h", n, bus.oPort, mPort); end
         checks++; if (bus.oStrobe !== mStrobe) begin errors++; $display("FAIL rnd_strobe n=%0d: got %b expected %b", n, bus.oStrobe, mStrobe); end
         checks++; if (bus.oFull !== mFull) begin errors++; $display("FAIL rnd_full n=%0d: got %b expected %b", n, bus.oFull, mFull); end
         checks++; if (bus.oSerial !== expSerial) begin errors++; $display("FAIL rnd_serial n=%0d: got %b expected %b", n, bus.oSerial, expSerial); end
         checks++; if (bus.oBusy !== (mElapsed >= 0)) begin errors++; $display("FAIL rnd_busy n=%0d: got %b expected %b", n, bus.oBusy, (mElapsed >= 0)); end
      end
      clearInputs();
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst = 1'b1;
      clearInputs();
      tick; tick;
      rst = 1'b0;
      tick;
      test_reset();
      test_load_ack();
      test_serial_frame();
      test_same_edge();
      test_reset_mid_frame();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/m_out_port.md
Name: m_out_port

Overview:
Bus-to-device output port; the receiving end of the shared 8-bit tristate data bus that input ports drive.
- Captures the bus value on a load command and presents it as a held parallel output.
- Runs a strobe/acknowledge handshake with the external device.
- Can optionally transmit the held byte as a serial frame (start bit, 8 data bits LSB first, stop bit), the SAP-2 serial output-port role.

Parameters:
WIDTH, 8, bus and port data width.
CLKS_PER_BIT, 4, clock cycles per serial bit; legal range is 1 and above.

Ports:
iClk  input  1  system clock; all state updates on the rising edge.
iReset  input  1  asynchronous, active-high reset.
iData  input  WIDTH  shared data bus value.
iLoad  input  1  latch iData into the port register at the next rising edge.
iSerialStart  input  1  request a serial transmission of the held byte.
iAck  input  1  external device acknowledge; it has consumed oPort.
oPort  output  WIDTH  held parallel output value.
oStrobe  output  1  one-cycle pulse marking new data on oPort.
oFull  output  1  data held and not yet acknowledged.
oSerial  output  1  serial line; idles high.
oBusy  output  1  serial frame in progress.

Behaviour:
- Reset (asynchronous, takes effect immediately, no clock needed):
  - oPort=0, oStrobe=0, oFull=0, oSerial=1, oBusy=0.
  - FSM goes to IDLE; bit and cycle counters clear.
  - A frame in progress is aborted with no partial stop bit.
- All outputs are registered.
- Load: a rising edge with iLoad=1 and oBusy=0 does the following.
  - oPort<=iData and oFull<=1.
  - oStrobe=1 for exactly the following cycle, then 0.
  - Loading while oFull=1 overwrites oPort (overrun is permitted) and strobes again.
- Load while oBusy=1 is ignored: oPort, oFull and oStrobe are unchanged, so the frame in flight is protected.
- Acknowledge:
  - iAck=1 at an edge with oFull=1 clears oFull.
  - iAck with oFull=0 has no effect.
  - An accepted iLoad and iAck at the same edge leave oFull=1 (load wins).
- Serial FSM states are IDLE, START, DATA and STOP.
  - IDLE: oSerial=1, oBusy=0. iSerialStart=1 at an edge with no accepted iLoad does three things: it snapshots oPort into the shift register, sets oBusy=1 and goes to START.
  - START: oSerial=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: oSerial carries shift-register bit 0, held CLKS_PER_BIT cycles per bit, LSB first. After WIDTH bits the FSM goes to STOP.
  - STOP: oSerial=1 for CLKS_PER_BIT cycles, then IDLE with oBusy=0.
- Frame timing:
  - The start bit appears the cycle after the accepting edge.
  - The total frame is (WIDTH+2)*CLKS_PER_BIT cycles of oBusy=1.
  - A new iSerialStart is accepted at the edge where STOP completes or later.
- iSerialStart while oBusy=1 is ignored; it is not queued.
- iLoad and iSerialStart at the same edge in IDLE: the load is accepted and the start is dropped; oBusy stays 0 and the host must re-request.
- A frame does not affect oFull and does not require it; the handshake and serial paths are independent.
- With CLKS_PER_BIT=1 each bit lasts exactly one cycle; the cycle counter must not underflow.

Test Plan:
1. Assert iReset mid-simulation with no clock edge → oPort=0x00, oStrobe=0, oFull=0, oSerial=1, oBusy=0 immediately.
2. iData=0xA5 with iLoad pulsed for one cycle → oPort=0xA5, oStrobe high for exactly one cycle, oFull=1. Then pulse iAck → oFull=0 at the next edge, oPort holds 0xA5.
3. CLKS_PER_BIT=4, oPort=0xA5, pulse iSerialStart → oSerial sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; oBusy high 40 cycles, then 0.
4. During test 3's frame, iData=0x3C with iLoad pulsed → oPort stays 0xA5, no strobe, oFull unchanged, serial waveform bit-identical.
5. Two same-edge cases:
   - oFull=1, iLoad with 0x11 and iAck at the same edge → oPort=0x11, oFull=1, strobe pulses.
   - iLoad and iSerialStart at the same edge in IDLE → load taken, oBusy stays 0, oSerial stays 1.
6. Assert iReset during the 3rd data bit of a frame → oSerial=1, oBusy=0, oPort=0 at once. After release, iSerialStart sends a complete frame of 0x00: start bit, eight 0 bits, stop bit.
